// File: rtl/inst_fetch_responder_pkg.sv
// Shared types for the instruction-fetch responder: FSM state encoding and the NOP reset instruction.
package inst_fetch_responder_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Fetch-port and backing-memory signals; the responder binds the slave modport, the core/memory side the master.
interface inst_fetch_responder_if;

    logic [31:0] inst_addr;
    logic [31:0] instruction;
    logic        inst_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        fetch_err;

    modport slave (
        input  inst_addr,
        input  mem_ack,
        input  mem_rdata,
        output instruction,
        output inst_ready,
        output mem_req,
        output mem_addr,
        output fetch_err
    );

    modport master (
        output inst_addr,
        output mem_ack,
        output mem_rdata,
        input  instruction,
        input  inst_ready,
        input  mem_req,
        input  mem_addr,
        input  fetch_err
    );

endinterface

// File: rtl/inst_fetch_responder_buffer.sv
// fetch_buffer: one-entry instruction buffer (tag, data, valid) used by the FETCH_PREFETCH_EN build.
module fetch_buffer
    import inst_fetch_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [29:0] wr_tag,
    input  logic [31:0] wr_data,
    input  logic [29:0] lookup_tag,
    output logic        hit,
    output logic [31:0] rd_data
);

    logic        valid_q;
    logic [29:0] tag_q;
    logic [31:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= NOP;
        end else if (wr_en) begin
            valid_q <= 1'b1;
            tag_q   <= wr_tag;
            data_q  <= wr_data;
        end
    end

    assign hit     = valid_q && (tag_q == lookup_tag);
    assign rd_data = data_q;

endmodule

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: turns the core's zero-wait fetch port into a req/ack handshake to slow memory.
// Define FETCH_PREFETCH_EN to add the one-entry buffer and next-line prefetch.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input logic                   clk,
    input logic                   rst,
    inst_fetch_responder_if.slave bus
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    fetch_state_t     state_q, state_d;
    logic [31:0]      instruction_q, instruction_d;
    logic             inst_ready_q, inst_ready_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic        ack;
    logic        addr_match;
    logic        deliver;
    logic [31:0] req_addr;
    logic        buf_hit;
    logic [31:0] buf_data;
    logic        issue_prefetch;
    logic        unused_addr_bits;

    // An ack only counts while a request is actually outstanding.
    assign ack              = bus.mem_ack && mem_req_q;
    assign req_addr         = {bus.inst_addr[31:2], 2'b00};
    assign addr_match       = (bus.inst_addr[31:2] == mem_addr_q[31:2]);
    assign deliver          = (state_q == REQ) && ack && addr_match;
    assign unused_addr_bits = ^bus.inst_addr[1:0];

`ifdef FETCH_PREFETCH_EN
    logic delivered_q;

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (deliver),
        .wr_tag     (mem_addr_q[31:2]),
        .wr_data    (bus.mem_rdata),
        .lookup_tag (bus.inst_addr[31:2]),
        .hit        (buf_hit),
        .rd_data    (buf_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delivered_q <= 1'b0;
        end else begin
            delivered_q <= deliver;
        end
    end

    assign issue_prefetch = delivered_q;
`else
    assign buf_hit        = 1'b0;
    assign buf_data       = NOP;
    assign issue_prefetch = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            instruction_q <= NOP;
            inst_ready_q  <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            fetch_err_q   <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            instruction_q <= instruction_d;
            inst_ready_q  <= inst_ready_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            fetch_err_q   <= fetch_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Redirects never withdraw a request: the stale one drains, or is replaced right after its ack.
    always_comb begin
        state_d       = state_q;
        instruction_d = instruction_q;
        inst_ready_d  = 1'b0;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        fetch_err_d   = fetch_err_q;
        wait_cnt_d    = wait_cnt_q;

        if (ack) begin
            wait_cnt_d = '0;
        end else if (mem_req_q && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        if (wait_cnt_d == CNT_MAX) begin
            fetch_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (issue_prefetch) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = mem_addr_q + 32'd4;
                    state_d    = REQ;
                end else if (buf_hit) begin
                    instruction_d = buf_data;
                    inst_ready_d  = 1'b1;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = req_addr;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (deliver) begin
                    instruction_d = bus.mem_rdata;
                    inst_ready_d  = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = IDLE;
                end else if (ack) begin
                    mem_addr_d = req_addr;
                end else if (!addr_match) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.instruction = instruction_q;
    assign bus.inst_ready  = inst_ready_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: core model, wait-state memory model and delivery scoreboard.
module tb_inst_fetch_responder;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic clk;
    logic rst;
    logic mem_ack_model;
    logic spurious_ack;
    logic mem_hold;
    int   mem_wait;
    int   req_cycles;
    int   n_compared;
    int   n_mismatched;
    int   seen_req;
    int   pf_count;
    int   pf_last;
    logic [31:0] exp_q[$];
    logic [31:0] pf_rec[$];

    inst_fetch_responder_if bus ();

    inst_fetch_responder #(.TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_ack = mem_ack_model | spurious_ack;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic expect_delivery);
        bus.inst_addr = addr;
        if (expect_delivery) exp_q.push_back(data_of(addr));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input string tag, output int reqs);
        reqs = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.inst_ready) return;
            if (bus.mem_req) reqs++;
        end
        checkOutput({tag, "_timeout"}, {31'b0, bus.inst_ready}, 32'd1);
    endtask

    // Memory: acks after mem_wait wait cycles unless held; a new request starts the cycle after an ack.
    always @(posedge clk or posedge rst) begin
        #1;
        if (rst) begin
            mem_ack_model = 1'b0;
            req_cycles    = 0;
        end else begin
            if (mem_ack_model) req_cycles = 0;
            if (bus.mem_req) begin
                mem_ack_model = !mem_hold && (req_cycles >= mem_wait);
                bus.mem_rdata = data_of(bus.mem_addr);
                req_cycles++;
            end else begin
                mem_ack_model = 1'b0;
                req_cycles    = 0;
            end
        end
    end

    // Scoreboard: every delivery must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus.inst_ready) begin
            if (exp_q.size() == 0) checkOutput("spurious_ready", {31'b0, bus.inst_ready}, 32'd0);
            else checkOutput("delivery", bus.instruction, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        spurious_ack  = 1'b0;
        mem_hold      = 1'b0;
        mem_wait      = 0;
        n_compared    = 0;
        n_mismatched  = 0;
        bus.inst_addr = '0;
        repeat (3) tick();
        checkOutput("rst_instruction", bus.instruction, NOP_WORD);
        checkOutput("rst_ready", {31'b0, bus.inst_ready}, 32'd0);
        checkOutput("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_fetch_err", {31'b0, bus.fetch_err}, 32'd0);

        // First miss with three wait cycles.
        mem_wait = 3;
        applyStimulus(32'h0000_1000, 1'b1);
        rst = 1'b0;
        tick();
        checkOutput("miss_req", {31'b0, bus.mem_req}, 32'd1);
        checkOutput("miss_addr", bus.mem_addr, 32'h0000_1000);
        wait_ready("miss", seen_req);
        checkOutput("miss_wait_cycles", seen_req, 32'd3);

        // Redirect while the request for 0x1004 is still waiting.
        applyStimulus(32'h0000_1004, 1'b0);
        mem_wait = 5;
        tick();
        checkOutput("ready_one_cycle", {31'b0, bus.inst_ready}, 32'd0);
        checkOutput("instr_hold", bus.instruction, data_of(32'h0000_1000));
        checkOutput("next_req_addr", bus.mem_addr, 32'h0000_1004);
        tick();
        applyStimulus(32'h0000_2000, 1'b1);
        for (int i = 0; i < 20 && bus.mem_req; i++) begin
            tick();
            if (bus.mem_req) checkOutput("drain_addr", bus.mem_addr, 32'h0000_1004);
            checkOutput("drain_no_ready", {31'b0, bus.inst_ready}, 32'd0);
        end
        checkOutput("drain_drop", {31'b0, bus.mem_req}, 32'd0);
        tick();
        checkOutput("redirect_req", {31'b0, bus.mem_req}, 32'd1);
        checkOutput("redirect_addr", bus.mem_addr, 32'h0000_2000);
        wait_ready("redirect", seen_req);

        // Ack timeout: fetch_err rises after 64 unacknowledged request cycles.
        applyStimulus(32'h0000_3000, 1'b1);
        mem_hold = 1'b1;
        tick();
        checkOutput("to_req", {31'b0, bus.mem_req}, 32'd1);
        for (int j = 1; j <= 64; j++) begin
            tick();
            if (j == 63) checkOutput("to_before", {31'b0, bus.fetch_err}, 32'd0);
        end
        checkOutput("to_err", {31'b0, bus.fetch_err}, 32'd1);
        checkOutput("to_still_waiting", {31'b0, bus.mem_req}, 32'd1);
        repeat (3) tick();
        mem_hold = 1'b0;
        wait_ready("to_release", seen_req);
        checkOutput("err_sticky", {31'b0, bus.fetch_err}, 32'd1);

        // Asynchronous reset in the middle of a fetch, then an ack with no request.
        applyStimulus(32'h0000_4000, 1'b0);
        mem_wait = 6;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("arst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("arst_ready", {31'b0, bus.inst_ready}, 32'd0);
        checkOutput("arst_instruction", bus.instruction, NOP_WORD);
        checkOutput("arst_fetch_err", {31'b0, bus.fetch_err}, 32'd0);
        checkOutput("arst_mem_addr", bus.mem_addr, 32'd0);
        tick();
        rst          = 1'b0;
        spurious_ack = 1'b1;
        applyStimulus(32'h0000_4000, 1'b1);
        tick();
        spurious_ack = 1'b0;
        checkOutput("spurious_no_ready", {31'b0, bus.inst_ready}, 32'd0);
        checkOutput("post_rst_addr", bus.mem_addr, 32'h0000_4000);
        wait_ready("post_rst", seen_req);

        // Zero-wait memory and an unaligned core address.
        applyStimulus(32'h0000_5003, 1'b1);
        mem_wait = 0;
`ifndef FETCH_PREFETCH_EN
        tick();
        checkOutput("aligned_addr", bus.mem_addr, 32'h0000_5000);
        tick();
        checkOutput("min_latency", {31'b0, bus.inst_ready}, 32'd1);
`else
        wait_ready("unaligned", seen_req);

        // Straight-line code with prefetch.
        applyStimulus(32'h0000_0100, 1'b1);
        pf_count = 0;
        pf_last  = 0;
        for (int cyc = 1; cyc <= 40 && pf_count < 3; cyc++) begin
            tick();
            if (bus.mem_req && ((pf_rec.size() == 0) ? (bus.mem_addr == 32'h0000_0100)
                                                     : (bus.mem_addr != pf_rec[$])))
                pf_rec.push_back(bus.mem_addr);
            if (bus.inst_ready) begin
                pf_count++;
                if (pf_count > 1) checkOutput("pf_gap_le2", {31'b0, (cyc - pf_last) <= 2}, 32'd1);
                pf_last = cyc;
                if (pf_count < 3) applyStimulus(bus.inst_addr + 32'd4, 1'b1);
            end
        end
        checkOutput("pf_deliveries", pf_count, 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("pf_addr_seq", (i < pf_rec.size()) ? pf_rec[i] : 32'hDEAD_DEAD,
                        32'h0000_0100 + 32'(4 * i));
        end

        // Prefetch across the top of the address space.
        applyStimulus(32'hFFFF_FFFC, 1'b1);
        wait_ready("wrap_first", seen_req);
        applyStimulus(32'h0000_0000, 1'b1);
        tick();
        checkOutput("wrap_req", {31'b0, bus.mem_req}, 32'd1);
        checkOutput("wrap_addr", bus.mem_addr, 32'h0000_0000);
        wait_ready("wrap_deliver", seen_req);
`endif

        mem_hold = 1'b1;
        repeat (6) tick();
        checkOutput("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/inst_fetch_responder.md
# inst_fetch_responder

Responder end of the core's instruction-fetch port: samples the word address the core presents on `inst_addr` every cycle and returns `instruction` with `inst_ready`. It converts that zero-wait fetch protocol into a req/ack handshake toward a slower backing memory (boot ROM or SRAM bridge). It tolerates arbitrary wait states and branch/jump redirects while a fetch is outstanding. Optionally it prefetches the next sequential word.

## Interface
- `TIMEOUT`, default 64: ack wait, in cycles, before `fetch_err` sets.
- `clk  in  1`: clock; all state on rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `inst_addr  in  32`: fetch address from the core; bits [1:0] ignored.
- `instruction  out  32`: instruction for the address sampled when it was delivered; registered.
- `inst_ready  out  1`: `instruction` valid this cycle; the core advances its PC on it; registered.
- `mem_req  out  1`: backing-memory request; held until ack; registered.
- `mem_addr  out  32`: word-aligned request address, {addr[31:2],2'b00}; stable while `mem_req`=1.
- `mem_ack  in  1`: one-cycle acknowledge; `mem_rdata` valid in the same cycle.
- `mem_rdata  in  32`: read data.
- `fetch_err  out  1`: sticky; set on ack timeout; cleared only by `rst`.

## Operation
- Reset values: `instruction`=NOP (32'h0000_0013, from the shared package), `inst_ready`=0, `mem_req`=0, `mem_addr`=0, `fetch_err`=0. The FSM resets to IDLE and the buffer is invalid.
- FSM states: IDLE, REQ, DRAIN.
- IDLE: compare `inst_addr[31:2]` each cycle.
  - Buffer hit: next cycle, `instruction`=buffered data and `inst_ready`=1.
  - Miss: next cycle, `mem_req`=1 with `mem_addr`={inst_addr[31:2],2'b00}; go to REQ.
- REQ: `inst_ready`=0. On `mem_ack`:
  - If `inst_addr[31:2]` still equals `mem_addr[31:2]`: next cycle `instruction`=`mem_rdata`, `inst_ready`=1, `mem_req`=0, and the FSM returns to IDLE.
  - Otherwise (redirect): the data is discarded and a new request for the current `inst_addr` is issued next cycle (REQ→REQ).
- A redirect seen before the ack moves REQ→DRAIN.
- DRAIN: `mem_req` stays high for the stale address; issued requests are never withdrawn. On `mem_ack`, data is discarded, `mem_req` drops for one cycle, and the FSM goes to IDLE, where the new address is evaluated.
- `inst_ready` is never high in two consecutive cycles for the same sampled address. Every delivery corresponds to exactly one sampled `inst_addr`.
- `mem_ack` while `mem_req`=0 is ignored.
- Timeout: a counter of width $clog2(TIMEOUT+1) counts cycles with `mem_req`=1 and no ack; it saturates at TIMEOUT.
  - Reaching TIMEOUT sets `fetch_err`.
  - The fetch keeps waiting.
  - The counter clears on each ack.
- `rst` mid-fetch: all outputs return to reset values immediately (asynchronously). A late `mem_ack` after reset is ignored per the rule above.

## Timing
- Miss latency: address sampled in cycle N, `mem_req` high in N+1, ack no earlier than N+1, `inst_ready` high one cycle after the ack (minimum N+2).
- Buffer hit latency: sampled in N, delivered in N+1. Back-to-back hits give `inst_ready`=1 every cycle.
- `instruction` holds its last value while `inst_ready`=0.

## Configuration
- `FETCH_PREFETCH_EN` defined: one-entry buffer (tag [31:2], data, valid) plus next-line prefetch.
  - Each delivery from memory is written into the buffer.
  - In the cycle after a delivery, a request for delivered address+4 is issued (state REQ tagged as prefetch).
  - A prefetch whose address matches `inst_addr` behaves as a normal REQ.
  - A non-matching prefetch goes to DRAIN.
  - The buffer is invalidated on reset only. Address wrap 32'hFFFF_FFFC+4 → 32'h0000_0000.
- Not defined: no buffer; every fetch is a miss; minimum 2-cycle latency; prefetch logic absent.

## Structure
- The shared `types` package gets `fetch_state_t` (IDLE/REQ/DRAIN) and reuses the existing NOP constant.
- Under the macro, one sub-module, `fetch_buffer` (tag/data/valid, write port, hit compare). Everything else stays inline.

## Test plan
- Reset release with `inst_addr`=32'h0000_1000 and ack after 3 wait cycles → `mem_req` high with `mem_addr`=32'h0000_1000 for 3 cycles, then `instruction`=`mem_rdata` and `inst_ready`=1 for exactly one cycle.
- Redirect to 32'h0000_2000 while the request for 32'h0000_1004 waits, then ack → stale data dropped, `inst_ready` stays 0, new request for 32'h0000_2000, delivered after its ack.
- Hold `mem_ack`=0 for 64 cycles → `fetch_err`=1 at cycle 64, stays 1 after a later ack, clears only on `rst`.
- Assert `rst` during REQ → `mem_req`=0, `inst_ready`=0, `instruction`=32'h0000_0013 without waiting for a clock edge; a following spurious `mem_ack` causes no delivery.
- `FETCH_PREFETCH_EN`, straight-line code from 32'h100 with zero-wait memory → after the first miss, `inst_ready` high every other cycle or better, and `mem_addr` sequence 100,104,108.
- `FETCH_PREFETCH_EN`, fetch 32'hFFFF_FFFC → prefetch `mem_addr`=32'h0000_0000.
